// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : HD44780 command bytes, line geometry and controller state codes.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] FUNC_8B_2L = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] ENTRY_INC  = 8'h06;
    localparam logic [7:0] CGRAM_BASE = 8'h40;
    localparam logic [7:0] DDRAM_L1   = 8'h80;
    localparam logic [7:0] DDRAM_L2   = 8'hC0;
    localparam int         LINE_LEN   = 40;

    typedef logic [2:0] ctrl_state_t;
    localparam ctrl_state_t ST_PWR     = 3'd0;
    localparam ctrl_state_t ST_INIT    = 3'd1;
    localparam ctrl_state_t ST_IDLE    = 3'd2;
    localparam ctrl_state_t ST_CG_ADDR = 3'd3;
    localparam ctrl_state_t ST_CG_DATA = 3'd4;
    localparam ctrl_state_t ST_CURSOR  = 3'd5;
    localparam ctrl_state_t ST_PLACE   = 3'd6;
    localparam ctrl_state_t ST_DONE    = 3'd7;

    typedef logic [1:0] phy_state_t;
    localparam phy_state_t PHY_IDLE  = 2'd0;
    localparam phy_state_t PHY_SETUP = 2'd1;
    localparam phy_state_t PHY_PULSE = 2'd2;
    localparam phy_state_t PHY_WAIT  = 2'd3;

    // Inputs never exceed 2*LINE_LEN-1, so one conditional subtract suffices.
    function automatic logic [5:0] wrap_col(input logic [6:0] c);
        logic [6:0] r;
        r = (c >= 7'(LINE_LEN)) ? (c - 7'(LINE_LEN)) : c;
        return r[5:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_write_phy.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_phy
// Brief    : One timed HD44780 bus write: setup, E pulse, settle wait, ack.
// Revision : 1.0
// ============================================================================
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int TICK_SETUP = 4,
    parameter int E_PULSE    = 25,
    parameter int CMD_WAIT   = 2500,
    parameter int CLR_WAIT   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       is_data_i,
    input  logic [7:0] byte_i,
    output logic       ack_o,
    output logic       rs_o,
    output logic       enable_o,
    output logic [7:0] data_o
);

    localparam int MAX_A  = (TICK_SETUP > E_PULSE) ? TICK_SETUP : E_PULSE;
    localparam int MAX_B  = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    phy_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_last;
    logic             rs_q, rs_d, en_q, en_d, ack_q, ack_d;
    logic [7:0]       data_q, data_d;

    // A clear-display needs the long settle time; everything else the short one.
    assign wait_last = (!rs_q && data_q == CLEAR) ? CNT_W'(CLR_WAIT - 1)
                                                  : CNT_W'(CMD_WAIT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rs_d    = rs_q;
        data_d  = data_q;
        en_d    = en_q;
        ack_d   = 1'b0;
        case (state_q)
            PHY_IDLE: begin
                cnt_d = '0;
                if (req_i) begin
                    rs_d    = is_data_i;
                    data_d  = byte_i;
                    state_d = PHY_SETUP;
                end
            end
            PHY_SETUP: begin
                if (cnt_q == CNT_W'(TICK_SETUP - 1)) begin
                    state_d = PHY_PULSE;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end
            end
            PHY_PULSE: begin
                if (cnt_q == CNT_W'(E_PULSE - 1)) begin
                    state_d = PHY_WAIT;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            end
            PHY_WAIT: begin
                if (cnt_q == wait_last) begin
                    state_d = PHY_IDLE;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = PHY_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PHY_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    assign ack_o    = ack_q;
    assign rs_o     = rs_q;
    assign enable_o = en_q;
    assign data_o   = data_q;

endmodule
`default_nettype wire

// File: rtl/lcd_glyph_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_glyph_ctrl
// Brief    : Uploads custom glyphs to CGRAM and places them as a 2-row block.
// Revision : 1.0
// ============================================================================
module lcd_glyph_ctrl
    import lcd_pkg::*;
#(
    parameter int TICK_SETUP = 4,
    parameter int E_PULSE    = 25,
    parameter int CMD_WAIT   = 2500,
    parameter int CLR_WAIT   = 100000,
    parameter int PWR_WAIT   = 1000000,
    parameter int NUM_GLYPHS = 8,
    parameter int GLYPH_ROWS = 8,
    localparam int AW        = $clog2(NUM_GLYPHS * GLYPH_ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [5:0]    col_i,
    input  logic [7:0]    glyph_data_i,
    output logic [AW-1:0] glyph_addr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          rs,
    output logic          rw,
    output logic          enable,
    output logic [7:0]    data
);

    localparam int TOTAL = NUM_GLYPHS * GLYPH_ROWS;
    localparam int HALF  = NUM_GLYPHS / 2;
    localparam int PWR_W = (PWR_WAIT > 1) ? $clog2(PWR_WAIT) : 1;

    ctrl_state_t      state_q, state_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic [1:0]       idx_q, idx_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             fetch_q, fetch_d, inflight_q, inflight_d;
    logic             req_q, req_d, isdata_q, isdata_d;
    logic [7:0]       byte_q, byte_d;
    logic [5:0]       col_q, col_d, pcol_q, pcol_d;
    logic             pend_q, pend_d, half_q, half_d;
    logic [2:0]       k_q, k_d, k_nxt;
    logic [5:0]       cur_col;
    logic             issue_en, issue_data, phy_ack;
    logic [7:0]       issue_byte;

    assign k_nxt   = k_q + 3'd1;
    assign cur_col = wrap_col(7'(col_q) + 7'(k_q));

    // Byte to launch when no write is outstanding; CG_DATA waits one fetch
    // cycle so the ROM output reflects the freshly advanced address.
    always_comb begin
        issue_en   = 1'b0;
        issue_data = 1'b0;
        issue_byte = 8'h00;
        if (!inflight_q) begin
            case (state_q)
                ST_INIT: begin
                    issue_en   = 1'b1;
                    issue_byte = (idx_q == 2'd0) ? FUNC_8B_2L :
                                 (idx_q == 2'd1) ? DISP_ON : CLEAR;
                end
                ST_CG_ADDR: begin
                    issue_en   = 1'b1;
                    issue_byte = CGRAM_BASE;
                end
                ST_CG_DATA: begin
                    issue_en   = fetch_q;
                    issue_data = 1'b1;
                    issue_byte = glyph_data_i & 8'h1F;
                end
                ST_CURSOR: begin
                    issue_en   = 1'b1;
                    issue_byte = (half_q ? DDRAM_L2 : DDRAM_L1) | {2'b00, cur_col};
                end
                ST_PLACE: begin
                    issue_en   = 1'b1;
                    issue_data = 1'b1;
                    issue_byte = (half_q ? 8'(HALF) : 8'h00) + {5'b00000, k_q};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        pwr_d      = pwr_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        fetch_d    = fetch_q;
        inflight_d = inflight_q;
        req_d      = 1'b0;
        isdata_d   = isdata_q;
        byte_d     = byte_q;
        col_d      = col_q;
        pcol_d     = pcol_q;
        pend_d     = pend_q;
        half_d     = half_q;
        k_d        = k_q;

        if (state_q != ST_IDLE && start_i) begin
            pend_d = 1'b1;
            pcol_d = col_i;
        end

        if (issue_en) begin
            req_d      = 1'b1;
            inflight_d = 1'b1;
            byte_d     = issue_byte;
            isdata_d   = issue_data;
            fetch_d    = 1'b0;
        end else if (state_q == ST_CG_DATA && !inflight_q) begin
            fetch_d = 1'b1;
        end

        if (inflight_q && phy_ack) begin
            inflight_d = 1'b0;
        end

        case (state_q)
            ST_PWR: begin
                if (pwr_q == PWR_W'(PWR_WAIT - 1)) begin
                    state_d = ST_INIT;
                    pwr_d   = '0;
                end else begin
                    pwr_d = pwr_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (inflight_q && phy_ack) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (start_i || pend_q) begin
                    col_d   = wrap_col(7'(start_i ? col_i : pcol_q));
                    pend_d  = 1'b0;
                    addr_d  = '0;
                    state_d = ST_CG_ADDR;
                end
            end
            ST_CG_ADDR: begin
                if (inflight_q && phy_ack) begin
                    state_d = ST_CG_DATA;
                end
            end
            ST_CG_DATA: begin
                if (inflight_q && phy_ack) begin
                    if (addr_q == AW'(TOTAL - 1)) begin
                        half_d  = 1'b0;
                        k_d     = 3'd0;
                        state_d = ST_CURSOR;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_CURSOR: begin
                if (inflight_q && phy_ack) begin
                    state_d = ST_PLACE;
                end
            end
            ST_PLACE: begin
                if (inflight_q && phy_ack) begin
                    if (k_nxt == 3'(HALF)) begin
                        k_d = 3'd0;
                        if (half_q) begin
                            state_d = ST_DONE;
                        end else begin
                            half_d  = 1'b1;
                            state_d = ST_CURSOR;
                        end
                    end else begin
                        k_d = k_nxt;
                        // DDRAM address would run off the line: re-aim at column 0.
                        if ((7'(col_q) + 7'(k_nxt)) == 7'(LINE_LEN)) begin
                            state_d = ST_CURSOR;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_PWR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_PWR;
            pwr_q      <= '0;
            idx_q      <= 2'd0;
            addr_q     <= '0;
            fetch_q    <= 1'b0;
            inflight_q <= 1'b0;
            req_q      <= 1'b0;
            isdata_q   <= 1'b0;
            byte_q     <= 8'h00;
            col_q      <= 6'd0;
            pcol_q     <= 6'd0;
            pend_q     <= 1'b0;
            half_q     <= 1'b0;
            k_q        <= 3'd0;
        end else begin
            state_q    <= state_d;
            pwr_q      <= pwr_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            fetch_q    <= fetch_d;
            inflight_q <= inflight_d;
            req_q      <= req_d;
            isdata_q   <= isdata_d;
            byte_q     <= byte_d;
            col_q      <= col_d;
            pcol_q     <= pcol_d;
            pend_q     <= pend_d;
            half_q     <= half_d;
            k_q        <= k_d;
        end
    end

    lcd_write_phy #(
        .TICK_SETUP (TICK_SETUP),
        .E_PULSE    (E_PULSE),
        .CMD_WAIT   (CMD_WAIT),
        .CLR_WAIT   (CLR_WAIT)
    ) u_phy (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_q),
        .is_data_i (isdata_q),
        .byte_i    (byte_q),
        .ack_o     (phy_ack),
        .rs_o      (rs),
        .enable_o  (enable),
        .data_o    (data)
    );

    assign glyph_addr_o = addr_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign rw           = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_glyph_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_glyph_ctrl
// Brief    : Randomised bench comparing captured LCD bus writes to a frame model.
// Revision : 1.0
// ============================================================================
module tb_lcd_glyph_ctrl;

    localparam int TS  = 2;
    localparam int EP  = 3;
    localparam int CW  = 5;
    localparam int CLW = 20;
    localparam int PW  = 10;
    localparam int NG  = 4;
    localparam int NB  = NG * 8;
    localparam int BOUND = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_i = 1'b0;
    logic [5:0] col_i = 6'd0;
    logic [7:0] glyph_data_i;
    logic [4:0] glyph_addr_o;
    logic       busy_o, done_o, rs, rw, enable;
    logic [7:0] data;

    always #5 clk = ~clk;

    lcd_glyph_ctrl #(
        .TICK_SETUP (TS), .E_PULSE (EP), .CMD_WAIT (CW), .CLR_WAIT (CLW),
        .PWR_WAIT (PW), .NUM_GLYPHS (NG), .GLYPH_ROWS (8)
    ) dut (
        .clk (clk), .reset (reset), .start_i (start_i), .col_i (col_i),
        .glyph_data_i (glyph_data_i), .glyph_addr_o (glyph_addr_o),
        .busy_o (busy_o), .done_o (done_o), .rs (rs), .rw (rw),
        .enable (enable), .data (data)
    );

    // Glyph ROM with one cycle of read latency.
    logic [7:0] rom [NB];
    always @(posedge clk) glyph_data_i <= rom[glyph_addr_o];

    int errors = 0;
    int checks = 0;
    logic [8:0] wr_q[$];
    logic [8:0] exp_q[$];

    // Bus monitor state
    int viol = 0, done_cnt = 0, strobes = 0;
    int hi_cnt = 0, low_cnt = 0, stable_cnt = 0, since_rst = 0, first_rise = -1;
    logic prev_en = 1'b0, prev_done = 1'b0, seen_fall = 1'b0;
    logic [8:0] prev_bus = 9'h0, last_wr = 9'h0;

    function automatic int req_wait(input logic [8:0] w);
        return (w == 9'h001) ? CLW : CW;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                hi_cnt = 0; low_cnt = 0; stable_cnt = 0; since_rst = 0; first_rise = -1;
                prev_en = 1'b0; prev_done = 1'b0; seen_fall = 1'b0; prev_bus = {rs, data};
            end else begin
                since_rst++;
                if (rw !== 1'b0) viol++;
                if ({rs, data} !== prev_bus) begin
                    if (enable) viol++;
                    if (seen_fall && low_cnt < req_wait(last_wr)) viol++;
                    stable_cnt = 0;
                end else begin
                    stable_cnt++;
                end
                if (enable && !prev_en) begin
                    if (stable_cnt < TS) viol++;
                    if (seen_fall && low_cnt < req_wait(last_wr) + TS) viol++;
                    if (first_rise < 0) first_rise = since_rst;
                    wr_q.push_back({rs, data});
                    last_wr = {rs, data};
                    strobes++;
                    hi_cnt = 1;
                end else if (enable) begin
                    hi_cnt++;
                end
                if (!enable && prev_en) begin
                    if (hi_cnt != EP) viol++;
                    seen_fall = 1'b1;
                    low_cnt = 0;
                end else if (!enable) begin
                    low_cnt++;
                end
                if (done_o) begin
                    done_cnt++;
                    if (prev_done) viol++;
                end
                prev_en = enable; prev_done = done_o; prev_bus = {rs, data};
            end
        end
    end

    // Reference model: the byte stream one frame must put on the bus.
    function automatic void model_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
    endfunction

    function automatic void model_frame(input int col);
        int c;
        exp_q.push_back(9'h040);
        for (int i = 0; i < NB; i++) exp_q.push_back({1'b1, rom[i] & 8'h1F});
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < NG / 2; k++) begin
                c = (col + k) % 40;
                if (k == 0 || c == 0)
                    exp_q.push_back({1'b0, 8'(128 + (h * 64) + c)});
                exp_q.push_back({1'b1, 8'(h * (NG / 2) + k)});
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int col);
        start_i = 1'b1; col_i = 6'(col);
        tick();
        start_i = 1'b0; col_i = 6'($urandom_range(0, 39));
    endtask

    task automatic wait_busy_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (!busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (done_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (wr_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [17:0] got;
        bit en_seen;
        #3 reset = 1'b0;
        #1 got = {rs, rw, enable, data, busy_o, done_o, glyph_addr_o};
        checks++;
        if (got !== {3'b000, 8'h00, 1'b1, 1'b0, 5'd0}) begin
            errors++; $display("FAIL reset_values: got %h want %h", got, {3'b000, 8'h00, 1'b1, 1'b0, 5'd0});
        end
        repeat (3) tick();
        wr_q.delete();
        reset = 1'b1;
        en_seen = 1'b0;
        for (int i = 0; i < PW; i++) begin
            tick();
            if (enable !== 1'b0) en_seen = 1'b1;
        end
        checks++;
        if (en_seen) begin errors++; $display("FAIL power_wait: enable high %0d want 0", en_seen); end
    endtask

    task automatic test_init();
        bit ok;
        wait_busy_low(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_timeout: busy %0d want 0", busy_o); end
        exp_q.delete(); model_init();
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++; $display("FAIL init_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL init_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (first_rise < PW) begin errors++; $display("FAIL first_strobe: got %0d want >=%0d", first_rise, PW); end
        checks++;
        if (low_cnt < CLW) begin errors++; $display("FAIL clear_gap: got %0d want >=%0d", low_cnt, CLW); end
    endtask

    task automatic test_frame_basic();
        bit ok;
        int d0;
        for (int i = 0; i < NB; i++) rom[i] = 8'(i);
        wr_q.delete(); d0 = done_cnt;
        pulse_start(3);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done %0d want 1", done_o); end
        exp_q.delete(); model_frame(3);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
            end
        end
        tick();
        checks++;
        if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want %0d", done_cnt - d0, 1); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle: busy %0d want 0", busy_o); end
    endtask

    task automatic test_col_wrap();
        bit ok;
        for (int i = 0; i < NB; i++) rom[i] = 8'($urandom);
        wr_q.delete();
        pulse_start(39);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: done %0d want 1", done_o); end
        exp_q.delete(); model_frame(39);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        int col;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NB; i++) rom[i] = 8'($urandom);
            col = (n == 0) ? 38 : int'($urandom_range(0, 39));
            repeat ($urandom_range(0, 5)) tick();
            wr_q.delete();
            pulse_start(col);
            wait_done(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_timeout[%0d]: done %0d want 1", n, done_o); end
            exp_q.delete(); model_frame(col);
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, wr_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_byte[%0d.%0d]: got %h want %h", n, i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int ca;
        int cols[3];
        for (int i = 0; i < NB; i++) rom[i] = 8'($urandom);
        ca = int'($urandom_range(0, 39));
        wr_q.delete();
        pulse_start(ca);
        wait_writes(5, ok);
        pulse_start(10);
        repeat (3) tick();
        pulse_start(22);
        cols[0] = ca; cols[1] = 22; cols[2] = 31;
        for (int f = 0; f < 3; f++) begin
            wait_done(ok);
            // A start in the DONE cycle must queue one more frame.
            if (f == 1) pulse_start(31);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_timeout[%0d]: done %0d want 1", f, done_o); end
            exp_q.delete(); model_frame(cols[f]);
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", f, wr_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_byte[%0d.%0d]: got %h want %h", f, i, wr_q[i], exp_q[i]);
                end
            end
            wr_q.delete();
        end
        repeat (40) tick();
        checks++;
        if (busy_o !== 1'b0 || wr_q.size() != 0) begin
            errors++; $display("FAIL b2b_extra_frame: busy %0d writes %0d want 0 0", busy_o, wr_q.size());
        end
    endtask

    task automatic test_start_in_init();
        bit ok;
        for (int i = 0; i < NB; i++) rom[i] = 8'($urandom);
        reset = 1'b0;
        repeat (2) tick();
        wr_q.delete();
        reset = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (enable) begin ok = 1'b1; break; end
        end
        pulse_start(5);
        col_i = 6'd17;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_start_timeout: done %0d want 1", done_o); end
        exp_q.delete(); model_init(); model_frame(5);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++; $display("FAIL init_start_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL init_start_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        logic [17:0] got;
        tick(); tick();
        for (int i = 0; i < NB; i++) rom[i] = 8'($urandom);
        wr_q.delete();
        pulse_start(int'($urandom_range(0, 39)));
        wait_writes(10, ok);
        #($urandom_range(1, 3));
        reset = 1'b0;
        #1 got = {rs, rw, enable, data, busy_o, done_o, glyph_addr_o};
        checks++;
        if (got !== {3'b000, 8'h00, 1'b1, 1'b0, 5'd0}) begin
            errors++; $display("FAIL midreset_values: got %h want %h", got, {3'b000, 8'h00, 1'b1, 1'b0, 5'd0});
        end
        repeat (3) tick();
        d0 = done_cnt;
        wr_q.delete();
        reset = 1'b1;
        wait_busy_low(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_timeout: busy %0d want 0", busy_o); end
        exp_q.delete(); model_init();
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL midreset_byte[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL midreset_done: got %0d want %0d", done_cnt - d0, 0); end
    endtask

    task automatic test_strobe_timing();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bus_timing: violations %0d want 0", viol); end
        checks++;
        if (strobes < 100) begin errors++; $display("FAIL strobe_total: got %0d want >=100", strobes); end
        checks++;
        if (rw !== 1'b0) begin errors++; $display("FAIL rw_level: got %0d want 0", rw); end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) rom[i] = 8'h00;
        test_reset();
        test_init();
        test_frame_basic();
        test_col_wrap();
        test_random_frames();
        test_back_to_back();
        test_start_in_init();
        test_reset_mid();
        test_strobe_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
